// File: rtl/vp_pixel_serializer.sv
// vp_pixel_serializer: buffers 64-bit pixel words (16 x 4-bit colour indices)
// in a small FIFO and emits one colour index per clock while draw is high.
// The leftmost pixel [63:60] of each word is emitted first. frame_start
// flushes everything.
// Optional feature macro: VP_SERIALIZER_HOLD_LAST_EN. When it is defined, an
// underflow repeats the last valid colour instead of BLANK_COLOR.
module vp_pixel_serializer #(
    parameter int         DEPTH       = 4,
    parameter logic [3:0] BLANK_COLOR = 4'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              pixels,
    input  logic                     enabled,
    input  logic                     frame_start,
    input  logic                     draw,
    output logic                     ready,
    output logic [3:0]               pixel,
    output logic                     pixel_valid,
    output logic                     underflow,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // FIFO storage and pointers; pointers wrap naturally because DEPTH is a power of two
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Output shifter: the next nibble to display is always at [63:60]
    logic [63:0]   r_shift;
    logic          r_shift_valid;
    logic [3:0]    r_cnt;

    logic [3:0]    r_pixel;
    logic          r_pixel_valid;
    logic          r_underflow;
    logic          r_overflow;

`ifdef VP_SERIALIZER_HOLD_LAST_EN
    logic [3:0]    r_last_color;
`endif

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Pop/push decisions. The pop happens when the shifter is idle or is
    // emitting its last nibble, so consecutive words stream without a bubble.
    // A pop the same cycle frees a slot, which lets a push into a full FIFO.
    always_comb begin
        w_empty = (r_level == '0);
        w_full  = (r_level == LW'(DEPTH));
        w_pop   = !frame_start && !w_empty &&
                  (!r_shift_valid || (draw && (r_cnt == 4'd15)));
        w_push  = !frame_start && enabled && (!w_full || w_pop);
        w_drop  = !frame_start && enabled && w_full && !w_pop;
    end

    // FIFO word storage (contents need no reset; validity is tracked by r_level)
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= pixels;
        end
    end

    // Pointers, level, shifter, output pixel and sticky flags
    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_shift       <= '0;
            r_shift_valid <= 1'b0;
            r_cnt         <= 4'd0;
            r_pixel       <= BLANK_COLOR;
            r_pixel_valid <= 1'b0;
            r_underflow   <= 1'b0;
            r_overflow    <= 1'b0;
`ifdef VP_SERIALIZER_HOLD_LAST_EN
            r_last_color  <= BLANK_COLOR;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            r_pixel       <= BLANK_COLOR;
            r_pixel_valid <= 1'b0;
            if (draw) begin
                if (r_shift_valid) begin
                    r_pixel       <= r_shift[63:60];
                    r_pixel_valid <= 1'b1;
                    r_shift       <= {r_shift[59:0], 4'h0};
                    r_cnt         <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_shift_valid <= 1'b0;
                    end
`ifdef VP_SERIALIZER_HOLD_LAST_EN
                    r_last_color  <= r_shift[63:60];
`endif
                end else begin
                    r_underflow <= 1'b1;
`ifdef VP_SERIALIZER_HOLD_LAST_EN
                    r_pixel     <= r_last_color;
`endif
                end
            end

            // A load overrides the shifter update above (same-cycle last nibble + reload)
            if (w_pop) begin
                r_shift       <= r_mem[r_rd_ptr];
                r_shift_valid <= 1'b1;
                r_cnt         <= 4'd0;
            end
        end
    end

    assign ready       = (r_level < LW'(DEPTH));
    assign pixel       = r_pixel;
    assign pixel_valid = r_pixel_valid;
    assign underflow   = r_underflow;
    assign overflow    = r_overflow;
    assign level       = r_level;

endmodule

// File: tb/tb_vp_pixel_serializer.sv
// Directed bench for vp_pixel_serializer (DEPTH=4, BLANK_COLOR=0).
// Expected pixels are queued when words are pushed and compared whenever
// the DUT reports pixel_valid.
module tb_vp_pixel_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pixels;
    logic        enabled;
    logic        frame_start;
    logic        draw;
    logic        ready;
    logic [3:0]  pixel;
    logic        pixel_valid;
    logic        underflow;
    logic        overflow;
    logic [2:0]  level;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [63:0] words[6];

`ifdef VP_SERIALIZER_HOLD_LAST_EN
    localparam logic [3:0] HOLD_EXP = 4'hA;
`else
    localparam logic [3:0] HOLD_EXP = 4'h0;
`endif

    vp_pixel_serializer #(.DEPTH(4), .BLANK_COLOR(4'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .pixels      (pixels),
        .enabled     (enabled),
        .frame_start (frame_start),
        .draw        (draw),
        .ready       (ready),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .underflow   (underflow),
        .overflow    (overflow),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the 16 nibbles of an accepted word, leftmost first
    task automatic expect_word(input logic [63:0] w);
        for (int k = 15; k >= 0; k--) exp_q.push_back(w[k*4 +: 4]);
    endtask

    // Advance one clock, sample 1 time unit later and score any valid pixel
    task automatic tick();
        @(posedge clk);
        #1;
        if (pixel_valid === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_pixel", {60'h0, pixel}, 64'hDEAD);
            else check("sb_pixel", {60'h0, pixel}, {60'h0, exp_q.pop_front()});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pixels = '0; enabled = 1'b0; frame_start = 1'b0; draw = 1'b0;
        tick(); tick();
        check("rst_pixel", {60'h0, pixel}, 64'h0);
        check("rst_valid", {63'h0, pixel_valid}, 64'h0);
        check("rst_underflow", {63'h0, underflow}, 64'h0);
        check("rst_overflow", {63'h0, overflow}, 64'h0);
        check("rst_level", {61'h0, level}, 64'h0);
        check("rst_ready", {63'h0, ready}, 64'h1);
        reset = 1'b0;

        // Single word, draw from cycle 2 after push: 0..F with no gaps
        pixels = 64'h0123_4567_89AB_CDEF; enabled = 1'b1; expect_word(pixels);
        tick();
        check("w1_level_after_push", {61'h0, level}, 64'h1);
        enabled = 1'b0;
        tick();
        check("w1_level_after_load", {61'h0, level}, 64'h0);
        draw = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("w1_valid", {63'h0, pixel_valid}, 64'h1);
        end
        draw = 1'b0;
        tick();
        check("w1_idle_valid", {63'h0, pixel_valid}, 64'h0);
        check("w1_idle_pixel", {60'h0, pixel}, 64'h0);
        check("w1_underflow", {63'h0, underflow}, 64'h0);
        check("w1_queue_drained", 64'(exp_q.size()), 64'h0);

        // Five back-to-back pushes: first loads the shifter, FIFO reaches 4
        for (int i = 0; i < 6; i++) words[i] = {$urandom, $urandom};
        enabled = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pixels = words[i]; expect_word(words[i]);
            tick();
            check("fill_level", {61'h0, level}, (i == 0) ? 64'h1 : 64'(i));
        end
        enabled = 1'b0;
        check("fill_ready_full", {63'h0, ready}, 64'h0);
        check("fill_overflow", {63'h0, overflow}, 64'h0);

        // Full FIFO: push coincides with pop at the last nibble of word 0
        draw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("full_draw_valid", {63'h0, pixel_valid}, 64'h1);
        end
        enabled = 1'b1; pixels = words[5]; expect_word(words[5]);
        tick();
        enabled = 1'b0;
        check("pushpop_level", {61'h0, level}, 64'h4);
        check("pushpop_overflow", {63'h0, overflow}, 64'h0);
        // Drain remaining five words continuously (covers word-boundary bubbles)
        for (int i = 0; i < 80; i++) begin
            tick();
            if (pixel_valid !== 1'b1) check("drain_valid", {63'h0, pixel_valid}, 64'h1);
        end
        n_tests++;
        draw = 1'b0;
        tick();
        check("drain_level", {61'h0, level}, 64'h0);
        check("drain_queue", 64'(exp_q.size()), 64'h0);
        check("drain_underflow", {63'h0, underflow}, 64'h0);

        // Overflow: fill to 4 with shifter loaded, sixth push dropped
        enabled = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pixels = words[i];
            tick();
        end
        enabled = 1'b0;
        check("ovf_flag", {63'h0, overflow}, 64'h1);
        check("ovf_level", {61'h0, level}, 64'h4);
        check("ovf_ready", {63'h0, ready}, 64'h0);

        // frame_start wins over simultaneous push and draw
        frame_start = 1'b1; enabled = 1'b1; draw = 1'b1; pixels = words[0];
        tick();
        frame_start = 1'b0; enabled = 1'b0; draw = 1'b0;
        check("fs_level", {61'h0, level}, 64'h0);
        check("fs_overflow", {63'h0, overflow}, 64'h0);
        check("fs_valid", {63'h0, pixel_valid}, 64'h0);
        check("fs_ready", {63'h0, ready}, 64'h1);
        tick();
        check("fs_push_ignored", {61'h0, level}, 64'h0);

        // Underflow on empty: blank output, sticky flag until frame_start
        draw = 1'b1;
        tick();
        draw = 1'b0;
        check("uf_pixel", {60'h0, pixel}, 64'h0);
        check("uf_valid", {63'h0, pixel_valid}, 64'h0);
        check("uf_flag", {63'h0, underflow}, 64'h1);
        tick(); tick();
        check("uf_sticky", {63'h0, underflow}, 64'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("uf_cleared", {63'h0, underflow}, 64'h0);
        check("uf_level", {61'h0, level}, 64'h0);

        // Word ending in A, then underflow: held colour or blank depending on build
        pixels = 64'hFEDC_BA98_7654_321A; enabled = 1'b1; expect_word(pixels);
        tick();
        enabled = 1'b0;
        tick();
        draw = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        tick();
        draw = 1'b0;
        check("hold_pixel", {60'h0, pixel}, {60'h0, HOLD_EXP});
        check("hold_valid", {63'h0, pixel_valid}, 64'h0);
        check("hold_underflow", {63'h0, underflow}, 64'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        draw = 1'b1;
        tick();
        draw = 1'b0;
        check("hold_after_fs_pixel", {60'h0, pixel}, 64'h0);
        check("hold_after_fs_valid", {63'h0, pixel_valid}, 64'h0);
        check("hold_queue", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vp_pixel_serializer.md
Name: vp_pixel_serializer

Overview:
- Downstream stage of the bitmap-to-pixels converter.
- Buffers 64-bit pixel words (16 pixels × 4-bit colour index) in a small FIFO.
- Emits one 4-bit colour index per clock while the video timing asserts `draw`.
- Decouples the bursty character-fetch pipeline from the steady pixel stream; flushed at every frame start.

Parameters:
- `DEPTH`, 4, FIFO depth in 64-bit words; power of two, 2..16.
- `BLANK_COLOR`, 4'd0, colour index emitted when no pixel data is available.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `pixels`  in  64  pixel word; `[63:60]` is the leftmost (first displayed) pixel, `[3:0]` the last
- `enabled`  in  1  `pixels` valid this cycle (push request)
- `frame_start`  in  1  synchronous flush pulse
- `draw`  in  1  display area active; consume one pixel this cycle
- `ready`  out  1  FIFO can accept a word next cycle (count < `DEPTH`)
- `pixel`  out  4  registered colour index
- `pixel_valid`  out  1  `pixel` came from real data
- `underflow`  out  1  sticky: `draw` occurred with no data
- `overflow`  out  1  sticky: push dropped because FIFO full
- `level`  out  $clog2(`DEPTH`)+1  FIFO word count

Behaviour:
- Reset:
  - FIFO empty, shifter empty, nibble counter 0.
  - `pixel` = `BLANK_COLOR`.
  - `pixel_valid`, `underflow`, `overflow` = 0.
  - `level` = 0; `ready` = 1.
- Storage:
  - FIFO of `DEPTH` × 64 registers, with write/read pointers that wrap modulo `DEPTH`.
  - Separate 64-bit shifter with a valid flag and a 4-bit nibble counter.
- Push:
  - `enabled`=1 and (not full, or a pop occurs the same cycle) → word stored; `level` visible the next cycle.
  - `enabled`=1 while full and no pop → word dropped, `overflow` set.
- Shifter load (pop):
  - Occurs when the shifter is empty, or when `draw`=1 and the counter=15, and the FIFO is non-empty.
  - Popped word enters the shifter with counter 0.
  - Load and the last-nibble output happen in the same cycle, so there is no gap between words.
  - When the FIFO is empty, a push goes straight to the FIFO. The shifter loads the following cycle.
  - Minimum latency from push to first `pixel_valid`: 3 cycles (push N, load N+1, `draw` at N+2 → output at N+3).
- Draw:
  - `draw`=1 with shifter valid → next cycle `pixel` = shifter nibble at `[63-4*cnt -: 4]`, `pixel_valid`=1, counter increments.
  - After nibble 15 the shifter becomes empty unless reloaded.
  - `draw`=1 with shifter empty → next cycle `pixel` = `BLANK_COLOR`, `pixel_valid`=0, `underflow` set.
  - `draw`=0 → `pixel` = `BLANK_COLOR`, `pixel_valid`=0, no state change.
- `frame_start`:
  - Highest priority after `reset`.
  - Empties the FIFO and shifter, zeroes pointers and counter, clears `underflow`/`overflow`.
  - A simultaneous push or `draw` is ignored.
  - Outputs for that cycle follow the `draw`=0 rule.
- Simultaneous push and pop on a full FIFO: both occur, `level` unchanged, `overflow` unchanged.
- `ready` is combinational from `level` (`level` < `DEPTH`).
- `level` counts FIFO words only and excludes the shifter.

Optional Feature:
- Macro `VP_SERIALIZER_HOLD_LAST_EN`.
- Defined: on underflow, `pixel` repeats the last valid colour index emitted instead of `BLANK_COLOR`. `pixel_valid`=0 and `underflow` set as usual. The last-colour register resets to `BLANK_COLOR` on `reset` and on `frame_start`.
- Undefined: underflow emits `BLANK_COLOR`, and no last-colour register exists.

Test Plan:
- Reset, push 64'h0123_4567_89AB_CDEF, then `draw` held 16 cycles from cycle 3 → `pixel` sequence 0,1,2,…,F with `pixel_valid`=1 throughout, `underflow`=0.
- Push 5 words back-to-back with `DEPTH`=4, no `draw` → first 4 words accepted (one loads the shifter, so `level` peaks at 3 then the 5th is accepted). Push a 6th → `overflow`=1 and `ready`=0 once `level`=4.
- Two words pushed, `draw` held 32 cycles → 32 consecutive valid pixels, with no bubble at the word boundary between cycles 16 and 17.
- `draw` with empty FIFO → `pixel`=`BLANK_COLOR` (0), `pixel_valid`=0, `underflow`=1 stays set. Then `frame_start` → `underflow`=0 and `level`=0.
- FIFO full, push and pop in the same cycle → `level` stays 4, `overflow` stays 0, and the new word appears in order after the existing words.
- With `VP_SERIALIZER_HOLD_LAST_EN`: emit a word ending in nibble A, then underflow → `pixel`=A, `pixel_valid`=0. After `frame_start` and an underflow → `pixel`=`BLANK_COLOR`.
